// File: rtl/max7219_frame_scheduler.sv
// MAX7219 traffic sequencer: setup words after reset, one six-digit refresh frame per
// tick edge, and config writes slotted in between frames. Drives the SPI master
// send/word/ready handshake, enforces the CS-high gap between words and recovers
// from a master that never acknowledges.
module max7219_frame_scheduler #(
  parameter logic [3:0]  INTENSITY  = 4'h5,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [2:0]  SCAN_LIMIT = 3'd5
) (
  input  logic        clk,
  input  logic        res,
  input  logic        ena,
  input  logic        tick,
  input  logic        skip_setup,
  input  logic [2:0]  min_X0,
  input  logic [3:0]  min_0X,
  input  logic [2:0]  sec_X0,
  input  logic [3:0]  sec_0X,
  input  logic [3:0]  ces_X0,
  input  logic [3:0]  ces_0X,
  input  logic        cfg_req,
  input  logic [15:0] cfg_word,
  output logic        cfg_ack,
  input  logic        spi_ready,
  output logic        spi_send,
  output logic [15:0] spi_word,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  output logic        err
);

  typedef enum logic [2:0] {
    StSetup,
    StIdle,
    StFrame,
    StIssue,
    StWaitLow,
    StWaitHigh,
    StGap
  } state_e;

  // Which sequence owns the shared issue/wait/gap path.
  typedef enum logic [1:0] {
    ModeSetup,
    ModeFrame,
    ModeCfg
  } mode_e;

  localparam logic [15:0] GapLast     = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e      state_q;
  mode_e       mode_q;
  logic [2:0]  idx_q;
  logic [15:0] cnt_q;
  logic        started_q;
  logic        tick_q;
  logic        frame_pending_q;

  logic [2:0]  snap_min_x0_q;
  logic [3:0]  snap_min_0x_q;
  logic [2:0]  snap_sec_x0_q;
  logic [3:0]  snap_sec_0x_q;
  logic [3:0]  snap_ces_x0_q;
  logic [3:0]  snap_ces_0x_q;

  logic        spi_send_q;
  logic [15:0] spi_word_q;
  logic        cfg_ack_q;
  logic        busy_q;
  logic        frame_done_q;
  logic        overrun_q;
  logic        err_q;

  logic [15:0] setup_word;
  logic [15:0] frame_word;
  logic        in_setup;
  logic        in_frame;
  logic        tick_edge;

  assign spi_send   = spi_send_q;
  assign spi_word   = spi_word_q;
  assign cfg_ack    = cfg_ack_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign err        = err_q;

  // Setup word for the current setup index.
  always_comb begin
    setup_word = 16'h0000;
    case (idx_q[1:0])
      2'd0:    setup_word = 16'h0C01;
      2'd1:    setup_word = {8'h0A, 4'h0, INTENSITY};
      2'd2:    setup_word = {8'h0B, 5'b0_0000, SCAN_LIMIT};
      default: setup_word = 16'h093F;
    endcase
  end

  // Digit word for the current frame index, built only from the snapshot.
  always_comb begin
    frame_word = 16'h0000;
    case (idx_q)
      3'd0:    frame_word = {8'h01, 4'h0, snap_ces_0x_q};
      3'd1:    frame_word = {8'h02, 4'h0, snap_ces_x0_q};
      3'd2:    frame_word = {8'h03, 4'h8, snap_sec_0x_q};
      3'd3:    frame_word = {8'h04, 5'h00, snap_sec_x0_q};
      3'd4:    frame_word = {8'h05, 4'h8, snap_min_0x_q};
      3'd5:    frame_word = {8'h06, 5'h00, snap_min_x0_q};
      default: frame_word = 16'h0000;
    endcase
  end

  // Tick edge qualification; edges during the setup sequence (or before boot) are dropped.
  always_comb begin
    in_setup  = !started_q || (state_q != StIdle && mode_q == ModeSetup);
    in_frame  = (state_q != StIdle) && (mode_q == ModeFrame);
    tick_edge = tick && !tick_q && ena && !in_setup;
  end

  // Sequencer FSM with registered handshake outputs and tick bookkeeping.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q         <= StSetup;
      mode_q          <= ModeSetup;
      idx_q           <= 3'd0;
      cnt_q           <= 16'd0;
      started_q       <= 1'b0;
      tick_q          <= 1'b0;
      frame_pending_q <= 1'b0;
      snap_min_x0_q   <= 3'd0;
      snap_min_0x_q   <= 4'd0;
      snap_sec_x0_q   <= 3'd0;
      snap_sec_0x_q   <= 4'd0;
      snap_ces_x0_q   <= 4'd0;
      snap_ces_0x_q   <= 4'd0;
      spi_send_q      <= 1'b0;
      spi_word_q      <= 16'h0000;
      cfg_ack_q       <= 1'b0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      overrun_q       <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      spi_send_q   <= 1'b0;
      cfg_ack_q    <= 1'b0;
      frame_done_q <= 1'b0;
      tick_q       <= tick;

      if (!started_q) begin
        // First clock after reset release decides whether setup is skipped.
        started_q <= 1'b1;
        mode_q    <= ModeSetup;
        idx_q     <= 3'd0;
        if (skip_setup) begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end else begin
          state_q <= StSetup;
          busy_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          StSetup: begin
            busy_q <= 1'b1;
            if (spi_ready) begin
              spi_send_q <= 1'b1;
              spi_word_q <= setup_word;
              state_q    <= StIssue;
            end
          end

          StIdle: begin
            busy_q <= 1'b0;
            if (spi_ready) begin
              if (frame_pending_q) begin
                frame_pending_q <= 1'b0;
                snap_min_x0_q   <= min_X0;
                snap_min_0x_q   <= min_0X;
                snap_sec_x0_q   <= sec_X0;
                snap_sec_0x_q   <= sec_0X;
                snap_ces_x0_q   <= ces_X0;
                snap_ces_0x_q   <= ces_0X;
                mode_q          <= ModeFrame;
                idx_q           <= 3'd0;
                state_q         <= StFrame;
                busy_q          <= 1'b1;
              end else if (cfg_req) begin
                spi_send_q <= 1'b1;
                spi_word_q <= cfg_word;
                cfg_ack_q  <= 1'b1;
                mode_q     <= ModeCfg;
                state_q    <= StIssue;
                busy_q     <= 1'b1;
              end
            end
          end

          StFrame: begin
            if (spi_ready) begin
              spi_send_q <= 1'b1;
              spi_word_q <= frame_word;
              state_q    <= StIssue;
            end
          end

          StIssue: begin
            cnt_q   <= 16'd0;
            state_q <= StWaitLow;
          end

          StWaitLow: begin
            if (!spi_ready) begin
              state_q <= StWaitHigh;
            end else if (cnt_q == TimeoutLast) begin
              // Master never took the word: flag it and restart the display setup.
              err_q   <= 1'b1;
              mode_q  <= ModeSetup;
              idx_q   <= 3'd0;
              state_q <= StSetup;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end

          StWaitHigh: begin
            if (spi_ready) begin
              cnt_q   <= 16'd0;
              state_q <= StGap;
            end
          end

          StGap: begin
            if (cnt_q == GapLast) begin
              case (mode_q)
                ModeSetup: begin
                  if (idx_q == 3'd3) begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                  end else begin
                    idx_q   <= idx_q + 3'd1;
                    state_q <= StSetup;
                  end
                end
                ModeFrame: begin
                  if (idx_q == 3'd5) begin
                    frame_done_q <= 1'b1;
                    state_q      <= StIdle;
                    busy_q       <= 1'b0;
                  end else begin
                    idx_q   <= idx_q + 3'd1;
                    state_q <= StFrame;
                  end
                end
                default: begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                end
              endcase
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end

          default: begin
            mode_q  <= ModeSetup;
            idx_q   <= 3'd0;
            state_q <= StSetup;
          end
        endcase
      end

      // Placed after the FSM so a same-cycle edge re-arms a pending frame just consumed.
      if (tick_edge) begin
        frame_pending_q <= 1'b1;
        if (frame_pending_q || in_frame) begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_max7219_frame_scheduler.sv
// Bench for max7219_frame_scheduler: a model SPI master plus a scoreboard of expected
// {cfg_ack, spi_word} values checked on every spi_send pulse.
module tb_max7219_frame_scheduler;

  localparam int GAP = 16;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        ena = 1'b0;
  logic        tick = 1'b0;
  logic        skip_setup = 1'b0;
  logic [2:0]  min_X0 = '0;
  logic [3:0]  min_0X = '0;
  logic [2:0]  sec_X0 = '0;
  logic [3:0]  sec_0X = '0;
  logic [3:0]  ces_X0 = '0;
  logic [3:0]  ces_0X = '0;
  logic        cfg_req = 1'b0;
  logic [15:0] cfg_word = '0;
  logic        cfg_ack;
  logic        spi_ready = 1'b1;
  logic        spi_send;
  logic [15:0] spi_word;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          fd_cnt = 0;
  int          mcnt = 0;
  int          rise_cyc = 0;
  int          send_cyc = 0;
  logic        have_rise = 1'b0;
  logic        stuck = 1'b0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  max7219_frame_scheduler #(
    .INTENSITY (4'h5),
    .GAP_CYCLES(GAP),
    .TIMEOUT   (TMO),
    .SCAN_LIMIT(3'd5)
  ) dut (
    .clk       (clk),
    .res       (res),
    .ena       (ena),
    .tick      (tick),
    .skip_setup(skip_setup),
    .min_X0    (min_X0),
    .min_0X    (min_0X),
    .sec_X0    (sec_X0),
    .sec_0X    (sec_0X),
    .ces_X0    (ces_X0),
    .ces_0X    (ces_0X),
    .cfg_req   (cfg_req),
    .cfg_word  (cfg_word),
    .cfg_ack   (cfg_ack),
    .spi_ready (spi_ready),
    .spi_send  (spi_send),
    .spi_word  (spi_word),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard compare plus master model; ready drops after a send, returns 64 cycles later.
  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    if (!res) begin
      spi_ready = 1'b1;
      mcnt      = 0;
      have_rise = 1'b0;
    end else begin
      if (frame_done) fd_cnt++;
      if (cfg_ack) check("ack_with_send", {31'b0, spi_send}, 32'd1);
      if (spi_send) begin
        send_cyc = cyc;
        e = (exp_q.size() > 0) ? {15'b0, exp_q.pop_front()} : 32'hDEAD_0000;
        check("word", {15'b0, cfg_ack, spi_word}, e);
        if (have_rise) check("gap", {31'b0, (cyc - rise_cyc) >= GAP}, 32'd1);
        if (!stuck) begin
          spi_ready = 1'b0;
          mcnt      = 64;
        end
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          spi_ready = 1'b1;
          rise_cyc  = cyc;
          have_rise = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic skip);
    res        = 1'b0;
    skip_setup = skip;
    repeat (3) step();
    check("reset_outs", {8'b0, spi_send, cfg_ack, busy, frame_done, overrun, err, spi_word},
          32'd0);
    res = 1'b1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    repeat (5) step();
    tick = 1'b0;
    repeat (5) step();
  endtask

  task automatic drain(input int budget, input string tag);
    int i = 0;
    while (i < budget && !(exp_q.size() == 0 && !busy)) begin
      step();
      i++;
    end
    check({tag, "_drain"}, exp_q.size(), 32'd0);
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic push_frame(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                            input logic [2:0] d3, input logic [3:0] d4, input logic [2:0] d5);
    exp_q.push_back({1'b0, 8'h01, 4'h0, d0});
    exp_q.push_back({1'b0, 8'h02, 4'h0, d1});
    exp_q.push_back({1'b0, 8'h03, 4'h8, d2});
    exp_q.push_back({1'b0, 8'h04, 5'h00, d3});
    exp_q.push_back({1'b0, 8'h05, 4'h8, d4});
    exp_q.push_back({1'b0, 8'h06, 5'h00, d5});
  endtask

  task automatic set_digits(input logic [2:0] mx0, input logic [3:0] m0x, input logic [2:0] sx0,
                            input logic [3:0] s0x, input logic [3:0] cx0, input logic [3:0] c0x);
    min_X0 = mx0; min_0X = m0x; sec_X0 = sx0; sec_0X = s0x; ces_X0 = cx0; ces_0X = c0x;
  endtask

  initial begin
    int fd0;
    int i;

    // Setup sequence after reset.
    exp_q.push_back({1'b0, 16'h0C01});
    exp_q.push_back({1'b0, 16'h0A05});
    exp_q.push_back({1'b0, 16'h0B05});
    exp_q.push_back({1'b0, 16'h093F});
    do_reset(1'b0);
    repeat (3) step();
    check("busy_in_setup", {31'b0, busy}, 32'd1);
    drain(2000, "setup");
    check("no_err_setup", {31'b0, err}, 32'd0);

    // Skip setup; ena gating; one frame.
    do_reset(1'b1);
    repeat (3) step();
    check("idle_after_skip", {31'b0, busy}, 32'd0);
    fd0 = fd_cnt;
    ena = 1'b0;
    set_digits(3'd5, 4'd9, 3'd5, 4'd9, 4'd9, 4'd9);
    pulse_tick();
    repeat (200) step();
    check("ena_gate", fd_cnt - fd0, 32'd0);
    ena = 1'b1;
    push_frame(4'd9, 4'd9, 4'd9, 3'd5, 4'd9, 3'd5);
    pulse_tick();
    drain(1500, "frame1");
    check("frame1_done", fd_cnt - fd0, 32'd1);

    // Snapshot held while inputs change mid-frame.
    set_digits(3'd1, 4'd2, 3'd3, 4'd4, 4'd5, 4'd6);
    push_frame(4'd6, 4'd5, 4'd4, 3'd3, 4'd2, 3'd1);
    pulse_tick();
    repeat (40) step();
    set_digits(3'd4, 4'd7, 3'd2, 4'd8, 4'd3, 4'd1);
    drain(1500, "snapshot");
    check("snapshot_done", fd_cnt - fd0, 32'd2);

    // Config request during a frame is served only after frame_done.
    push_frame(4'd1, 4'd3, 4'd8, 3'd2, 4'd7, 3'd4);
    pulse_tick();
    repeat (90) step();
    cfg_word = 16'h0A0F;
    cfg_req  = 1'b1;
    exp_q.push_back({1'b1, 16'h0A0F});
    i = 0;
    while (i < 1500 && !cfg_ack) begin
      step();
      i++;
    end
    check("cfg_ack_seen", {31'b0, cfg_ack}, 32'd1);
    check("cfg_after_frame", fd_cnt - fd0, 32'd3);
    cfg_req = 1'b0;
    step();
    check("ack_one_cycle", {31'b0, cfg_ack}, 32'd0);
    drain(500, "cfg");

    // Two extra edges inside one frame: overrun, exactly one more frame.
    check("overrun_clear", {31'b0, overrun}, 32'd0);
    push_frame(4'd1, 4'd3, 4'd8, 3'd2, 4'd7, 3'd4);
    push_frame(4'd1, 4'd3, 4'd8, 3'd2, 4'd7, 3'd4);
    pulse_tick();
    repeat (20) step();
    pulse_tick();
    repeat (20) step();
    pulse_tick();
    drain(3000, "overrun");
    check("overrun_set", {31'b0, overrun}, 32'd1);
    repeat (300) step();
    check("overrun_frames", fd_cnt - fd0, 32'd5);
    check("overrun_no_extra", exp_q.size(), 32'd0);

    // Master never drops ready: timeout, err, setup restarts.
    stuck = 1'b1;
    exp_q.push_back({1'b0, 16'h0C01});
    do_reset(1'b0);
    check("err_clear_after_reset", {31'b0, err}, 32'd0);
    i = 0;
    while (i < 1000 && !err) begin
      step();
      i++;
    end
    check("err_set", {31'b0, err}, 32'd1);
    check("timeout_len", {31'b0, (cyc - send_cyc) >= TMO && (cyc - send_cyc) <= TMO + 2},
          32'd1);
    stuck = 1'b0;
    exp_q.push_back({1'b0, 16'h0C01});
    exp_q.push_back({1'b0, 16'h0A05});
    exp_q.push_back({1'b0, 16'h0B05});
    exp_q.push_back({1'b0, 16'h093F});
    drain(2500, "recover");
    check("err_sticky", {31'b0, err}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
